// File: rtl/fsquare.sv
`default_nettype none
// ============================================================================
//  Module   : fsquare
//  Purpose  : Three-stage pipelined IEEE-754 single-precision squarer (y = x*x)
//             with valid/ready handshake on both sides. Denormals flush to
//             zero, rounding is round-to-nearest-even, and the sign is always 0.
//  Options  : FSQUARE_FLAGS_EN - when defined, adds the registered 3-bit
//             {overflow, underflow, inexact} flags output.
//  Revision : 1.0 - initial release
// ============================================================================
module fsquare (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FSQUARE_FLAGS_EN
    ,
    output logic [2:0]  flags
`endif
);

    localparam logic [31:0] c_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] c_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] c_ZERO    = 32'h0000_0000;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic        r_s1_valid;
    logic [7:0]  r_s1_exp;
    logic [22:0] r_s1_man;

    logic        r_s2_valid;
    logic [7:0]  r_s2_exp;
    logic        r_s2_man_nz;
    logic [47:0] r_s2_prod;

    logic        r_out_valid;
    logic [31:0] r_y;

    // Whole pipe moves as one: it only stalls when a finished result sits
    // unconsumed in the output register.
    logic w_advance;
    assign w_advance = !r_out_valid || out_ready;

    // Reset forces in_ready high so the upstream never sees a stall during reset;
    // the stage registers ignore the input while reset is asserted.
    assign in_ready  = rst || w_advance;
    assign out_valid = r_out_valid;
    assign y         = r_y;

    // ------------------------------------------------------------------
    // S1: unpack the operand; the sign is dropped since x*x is never negative
    // ------------------------------------------------------------------
    // Stage 1 register: capture exponent and fraction on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_exp   <= 8'd0;
            r_s1_man   <= 23'd0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_exp <= x[30:23];
                r_s1_man <= x[22:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: 24x24 significand multiply
    // ------------------------------------------------------------------
    logic [23:0] w_sig;
    logic [47:0] w_prod;
    assign w_sig  = {1'b1, r_s1_man};
    assign w_prod = {24'd0, w_sig} * {24'd0, w_sig};

    // Stage 2 register: full 48-bit product plus what S3 needs for specials.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_exp    <= 8'd0;
            r_s2_man_nz <= 1'b0;
            r_s2_prod   <= 48'd0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_exp    <= r_s1_exp;
                r_s2_man_nz <= |r_s1_man;
                r_s2_prod   <= w_prod;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: normalize, round, range-check and pack
    // ------------------------------------------------------------------
    logic              w_p47;
    logic [22:0]       w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic              w_round_up;
    logic [23:0]       w_mant_rnd;
    logic              w_carry;
    logic [9:0]        w_exp2;
    logic signed [9:0] w_er;
    logic              w_ovf;
    logic              w_unf;
    logic              w_inexact;
    logic [31:0]       w_y_next;

    // Normalize by 23 or 24 bits, round to nearest-even, then classify the result.
    always_comb begin
        w_p47      = r_s2_prod[47];
        w_mant     = r_s2_prod[45:23];
        w_guard    = r_s2_prod[22];
        w_sticky   = |r_s2_prod[21:0];
        if (w_p47) begin
            w_mant   = r_s2_prod[46:24];
            w_guard  = r_s2_prod[23];
            w_sticky = |r_s2_prod[22:0];
        end
        w_round_up = w_guard & (w_sticky | w_mant[0]);
        w_mant_rnd = {1'b0, w_mant} + {23'd0, w_round_up};
        // A carry out of the fraction means it wrapped to zero: value is 2.0,
        // which is 1.0 with the exponent bumped.
        w_carry    = w_mant_rnd[23];
        w_exp2     = {1'b0, r_s2_exp, 1'b0};
        w_er       = $signed(w_exp2) - 10'sd127
                   + $signed({9'd0, w_p47}) + $signed({9'd0, w_carry});
        w_ovf      = (w_er >= 10'sd255);
        w_unf      = (w_er <= 10'sd0);
        w_inexact  = w_guard | w_sticky;

        w_y_next = c_ZERO;
        if (r_s2_exp == 8'd0) begin
            w_y_next = c_ZERO;
        end else if (r_s2_exp == 8'hFF) begin
            w_y_next = r_s2_man_nz ? c_QNAN : c_POS_INF;
        end else if (w_ovf) begin
            w_y_next = c_POS_INF;
        end else if (w_unf) begin
            w_y_next = c_ZERO;
        end else begin
            w_y_next = {1'b0, w_er[7:0], w_mant_rnd[22:0]};
        end
    end

    // Stage 3 register: the visible result, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= c_ZERO;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_y <= w_y_next;
            end
        end
    end

`ifdef FSQUARE_FLAGS_EN
    logic [2:0] w_flags_next;
    logic [2:0] r_flags;

    // Exception flags; the zero/denormal/inf/NaN input cases report nothing.
    always_comb begin
        w_flags_next = 3'b000;
        if (r_s2_exp != 8'd0 && r_s2_exp != 8'hFF) begin
            if (w_ovf) begin
                w_flags_next = 3'b101;
            end else if (w_unf) begin
                w_flags_next = 3'b011;
            end else begin
                w_flags_next = {2'b00, w_inexact};
            end
        end
    end

    // Flags register, updated in lockstep with y.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else if (w_advance && r_s2_valid) begin
            r_flags <= w_flags_next;
        end
    end

    assign flags = r_flags;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsquare.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsquare
//  Purpose  : Self-checking bench for fsquare. Expected results are queued on
//             each accepted operand and compared as results are consumed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsquare;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
`ifdef FSQUARE_FLAGS_EN
    logic [2:0]  flags;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [34:0] sb[$];
    logic [34:0] m_exp;
    bit          stop_toggle;

    always #5 clk = ~clk;

    fsquare dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FSQUARE_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    // Reference: exact integer product, explicit remainder-based RNE rounding.
    // Returns {overflow, underflow, inexact, y}.
    function automatic logic [34:0] model(input logic [31:0] a);
        int               e;
        int               sh;
        longint unsigned  m, p, q, rem, half;
        logic [7:0]       ea;
        ea = a[30:23];
        if (ea == 8'd0) return 35'd0;
        if (ea == 8'hFF) return {3'b000, (a[22:0] == 23'd0) ? 32'h7F800000 : 32'h7FC00000};
        m    = {40'd0, 1'b1, a[22:0]};
        p    = m * m;
        sh   = (p >= (64'd1 << 47)) ? 24 : 23;
        e    = 2 * int'(ea) - 127 + (sh - 23);
        q    = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {3'b101, 32'h7F800000};
        if (e <= 0)   return {3'b011, 32'h00000000};
        return {2'b00, (rem != 64'd0), 1'b0, 8'(e), q[22:0]};
    endfunction

    // Scoreboard: every consumed result must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got y=%h with nothing pending, expected no result", y);
            end else begin
                m_exp = sb.pop_front();
                if (y !== m_exp[31:0]) begin
                    bad++;
                    $display("FAIL sb_y: got %h expected %h", y, m_exp[31:0]);
                end
`ifdef FSQUARE_FLAGS_EN
                total++;
                if (flags !== m_exp[34:32]) begin
                    bad++;
                    $display("FAIL sb_flags: got %b expected %b (y=%h)", flags, m_exp[34:32], m_exp[31:0]);
                end
`endif
            end
        end
    end

    // Offer one operand until accepted; queue its expectation on the transfer.
    task automatic send(input logic [31:0] v, input logic [34:0] e);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        x = v;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready=%b for 200 cycles, expected 1", in_ready);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Wait for all queued results to be consumed, within a bounded time.
    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results missing, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        x = 32'h40000000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++;
        if (y !== 32'h0) begin bad++; $display("FAIL reset_y: got %h expected 00000000", y); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef FSQUARE_FLAGS_EN
        total++;
        if (flags !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b expected 000", flags); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_no_capture: got out_valid=%b expected 0", out_valid); end
        end
        @(posedge clk);
        #1;
    endtask

    // Single 2.0 operand: result valid exactly on the third edge, for one cycle.
    task automatic test_latency();
        logic exp_ov[4];
        exp_ov = '{1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        x = 32'h40000000;
        in_valid = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready: got %b expected 1", in_ready); end
        sb.push_back({3'b000, 32'h40800000});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== exp_ov[i]) begin
                bad++;
                $display("FAIL lat_out_valid[%0d]: got %b expected %b", i + 1, out_valid, exp_ov[i]);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(32'h3FC00000, {3'b000, 32'h40100000});
        send(32'h40400000, {3'b000, 32'h41100000});
        send(32'hC0400000, {3'b000, 32'h41100000});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== (i < 3)) begin
                bad++;
                $display("FAIL b2b_out_valid[%0d]: got %b expected %b", i, out_valid, (i < 3));
            end
        end
        drain();
    endtask

    task automatic test_rounding();
        out_ready = 1'b1;
        send(32'h3FFFFFFF, {3'b001, 32'h407FFFFE});
        send(32'h3F800800, {3'b001, 32'h3F801000});
        send(32'h3F800000, {3'b000, 32'h3F800000});
        send(32'h5F000000, {3'b000, 32'h7E800000});
        send(32'h20000000, {3'b000, 32'h00800000});
        send(32'h1FFFFFFF, {3'b011, 32'h00000000});
        drain();
    endtask

    task automatic test_special();
        out_ready = 1'b1;
        send(32'h7F000000, {3'b101, 32'h7F800000});
        send(32'h1F800000, {3'b011, 32'h00000000});
        send(32'h7F800001, {3'b000, 32'h7FC00000});
        send(32'h00000001, {3'b000, 32'h00000000});
        send(32'h7F800000, {3'b000, 32'h7F800000});
        send(32'hFF800000, {3'b000, 32'h7F800000});
        send(32'h5F800000, {3'b101, 32'h7F800000});
        send(32'h80000000, {3'b000, 32'h00000000});
        drain();
    endtask

    // Output blocked: three operands fill the pipe, then input stalls and y holds.
    task automatic test_stall();
        logic [31:0] ops[5];
        ops = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h41000000, 32'h3F800000};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(ops[i], model(ops[i]));
        x = ops[3];
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid[%0d]: got %b expected 1", i, out_valid); end
            total++;
            if (y !== sb[0][31:0]) begin bad++; $display("FAIL stall_y_hold[%0d]: got %h expected %h", i, y, sb[0][31:0]); end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(ops[3], model(ops[3]));
        send(ops[4], model(ops[4]));
        drain();
    endtask

    // Reset with a full pipe: everything in flight is discarded.
    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send(32'h40000000, model(32'h40000000));
        send(32'h40400000, model(32'h40400000));
        send(32'h41000000, model(32'h41000000));
        rst = 1'b1;
        x = 32'h40A00000;
        in_valid = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        total++;
        if (y !== 32'h0) begin bad++; $display("FAIL rstmid_y: got %h expected 00000000", y); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale[%0d]: got out_valid=%b expected 0", i, out_valid); end
        end
        @(posedge clk);
        #1;
        send(32'h40A00000, {3'b000, 32'h41C80000});
        drain();
    endtask

    // Random operands with random input gaps and random output back-pressure.
    task automatic test_random();
        logic [31:0] v;
        stop_toggle = 1'b0;
        fork
            begin
                while (!stop_toggle) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom % 3 != 0);
                end
            end
        join_none
        for (int i = 0; i < 60; i++) begin
            if ($urandom % 4 == 0) begin
                @(posedge clk);
                #1;
            end
            v = $urandom;
            if ($urandom % 4 != 0) v[30:23] = 8'($urandom_range(40, 210));
            send(v, model(v));
        end
        stop_toggle = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_rounding();
        test_special();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
